// File: rtl/lock_pkg.sv
// Shared lock definitions: compare selectors and key codes.
// Used by the lock controller and the code matcher.
package lock_pkg;

  typedef enum logic [1:0] {
    COMPAREPC = 2'b00,
    COMPAREUC = 2'b01,
    MATCHUC   = 2'b10,
    STOREUC   = 2'b11
  } cmp_e;

  localparam logic [3:0] KEY_CANCEL = 4'd7;
  localparam logic [3:0] KEY_PROG   = 4'd8;
  localparam logic [3:0] KEY_LOCK   = 4'd9;
  localparam logic [3:0] KEY_DIGMAX = 4'd6;

  function automatic logic is_cmd(
    input logic [3:0] k
  );
    return (k == KEY_CANCEL) ||
           (k == KEY_PROG) ||
           (k == KEY_LOCK);
  endfunction

endpackage

// File: rtl/digit_entry.sv
// Key-release detection and the open-entry digit buffer.
// Tracks entry length and overflow, strobes close on command keys.
module digit_entry
  import lock_pkg::*;
#(
  parameter int MAX_DIGITS = 6,
  parameter int LW = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    hwclk,
  input  logic                    rst,
  input  logic [3:0]              button,
  input  logic                    bstate,
  input  logic                    read_input,
  output logic                    close,
  output logic [MAX_DIGITS*4-1:0] ent,
  output logic [LW-1:0]           ent_len,
  output logic                    ovf
);

  logic prev_b;
  logic prev_ri;
  logic rel;
  logic ri_fall;
  logic dig;

  assign rel     = prev_b & ~bstate;
  assign ri_fall = prev_ri & ~read_input;
  assign close   = rel & is_cmd(button);
  assign dig     = rel & read_input &
                   (button <= KEY_DIGMAX);

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      prev_b  <= 1'b0;
      prev_ri <= 1'b0;
      ent     <= '0;
      ent_len <= '0;
      ovf     <= 1'b0;
    end else begin
      prev_b  <= bstate;
      prev_ri <= read_input;
      // A close wins over a capture; a falling read_input only clears.
      if (close || ri_fall) begin
        ent     <= '0;
        ent_len <= '0;
        ovf     <= 1'b0;
      end else if (dig) begin
        if (ent_len < LW'(MAX_DIGITS)) begin
          for (int i = 0; i < MAX_DIGITS; i++) begin
            if (ent_len == LW'(i)) begin
              ent[i*4 +: 4] <= button;
            end
          end
          ent_len <= ent_len + LW'(1);
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/code_matcher.sv
// Keypad code buffer and comparator for the digital lock.
// Holds last entry, staged code and user code; compares and commits.
module code_matcher
  import lock_pkg::*;
#(
  parameter int MAX_DIGITS = 6,
  parameter int MIN_DIGITS = 4,
  parameter int PC_LEN = 4,
  parameter logic [MAX_DIGITS*4-1:0] PC_CODE = 'h1234,
  parameter logic [MAX_DIGITS*4-1:0] DEFAULT_UC = 'h0000,
  parameter int DEFAULT_UC_LEN = 4
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic [3:0] button,
  input  logic       bstate,
  input  logic       read_input,
  input  logic       store,
  input  logic [1:0] compareType,
  output logic       correct_input,
  output logic       validLength,
  output logic       validLengthPC,
  output logic       data_ready
);

  localparam int W  = MAX_DIGITS * 4;
  localparam int LW = $clog2(MAX_DIGITS + 1);

  logic          close;
  logic [W-1:0]  ent;
  logic [LW-1:0] ent_len;
  logic          ovf;

  logic [W-1:0]  last;
  logic [LW-1:0] last_len;
  logic          last_ovf;
  logic [W-1:0]  staged;
  logic [LW-1:0] staged_len;
  logic [W-1:0]  uc;
  logic [LW-1:0] uc_len;

  logic [W-1:0]  tgt;
  logic [LW-1:0] tgt_len;
  logic          tgt_en;
  cmp_e          ct;

  digit_entry #(
    .MAX_DIGITS(MAX_DIGITS),
    .LW        (LW)
  ) u_entry (
    .hwclk     (hwclk),
    .rst       (rst),
    .button    (button),
    .bstate    (bstate),
    .read_input(read_input),
    .close     (close),
    .ent       (ent),
    .ent_len   (ent_len),
    .ovf       (ovf)
  );

  assign ct = cmp_e'(compareType);

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      last       <= '0;
      last_len   <= '0;
      last_ovf   <= 1'b0;
      staged     <= '0;
      staged_len <= '0;
      uc         <= DEFAULT_UC;
      uc_len     <= LW'(DEFAULT_UC_LEN);
      data_ready <= 1'b0;
    end else begin
      data_ready <= close;
      if (close) begin
        last     <= ent;
        last_len <= ent_len;
        last_ovf <= ovf;
      end
      if (close && (ct == STOREUC)) begin
        staged     <= ent;
        staged_len <= ovf ? '0 : ent_len;
      end
      // Short or overflowed staged codes are never committed.
      if (store && (staged_len >= LW'(MIN_DIGITS))) begin
        uc     <= staged;
        uc_len <= staged_len;
      end
    end
  end

  always_comb begin
    tgt     = '0;
    tgt_len = '0;
    tgt_en  = 1'b1;
    unique case (ct)
      COMPAREPC: begin
        tgt     = PC_CODE;
        tgt_len = LW'(PC_LEN);
      end
      COMPAREUC: begin
        tgt     = uc;
        tgt_len = uc_len;
      end
      MATCHUC: begin
        tgt     = staged;
        tgt_len = staged_len;
      end
      STOREUC: begin
        tgt_en = 1'b0;
      end
    endcase
  end

  assign correct_input = tgt_en & ~last_ovf &
                         (last_len != '0) &
                         (last_len == tgt_len) &
                         (last == tgt);

  assign validLength = ~ovf &
                       (ent_len >= LW'(MIN_DIGITS)) &
                       (ent_len <= LW'(MAX_DIGITS));

  assign validLengthPC = ~ovf &
                         (ent_len == LW'(PC_LEN));

endmodule
